// File: rtl/dmem_uart.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | dmem_uart : word-addressed data RAM with a memory-mapped UART TX port  |
// | Revision  : 1.0                                                        |
// +------------------------------------------------------------------------+

module dmem_uart #(
   parameter int RAM_WORDS    = 1024,
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] mem_addr,
   input  logic        mem_r_enable,
   input  logic        mem_w_enable,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        uart_tx
);

   localparam int c_AW = $clog2(RAM_WORDS);
   localparam int c_PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int c_CW = $clog2(FIFO_DEPTH + 1);
   localparam int c_BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   localparam logic [31:0]     c_TXDATA_ADDR = 32'h1000_0000;
   localparam logic [31:0]     c_STATUS_ADDR = 32'h1000_0004;
   localparam logic [c_PW-1:0] c_PTR_LAST    = c_PW'(FIFO_DEPTH - 1);
   localparam logic [c_CW-1:0] c_COUNT_FULL  = c_CW'(FIFO_DEPTH);
   localparam logic [c_BW-1:0] c_BAUD_LAST   = c_BW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_t;

   logic [31:0]     r_ram [RAM_WORDS];
   logic [7:0]      r_fifo [FIFO_DEPTH];
   logic [c_PW-1:0] r_wptr;
   logic [c_PW-1:0] r_rptr;
   logic [c_CW-1:0] r_count;
   logic            r_overflow;
   tx_state_t       r_state;
   logic [c_BW-1:0] r_baud;
   logic [2:0]      r_bit;
   logic [7:0]      r_shift;

   logic [c_AW-1:0] w_ram_idx;
   logic            w_sel_ram;
   logic            w_sel_tx;
   logic            w_sel_st;
   logic            w_wr;
   logic            w_fifo_full;
   logic            w_fifo_empty;
   logic            w_push;
   logic            w_pop;
   logic            w_tx_busy;
   logic [31:0]     w_status;

   function automatic logic [c_PW-1:0] ptr_next(input logic [c_PW-1:0] p);
      return (p == c_PTR_LAST) ? '0 : p + c_PW'(1);
   endfunction

   assign w_ram_idx    = mem_addr[c_AW+1:2];
   assign w_sel_ram    = (mem_addr[31:28] == 4'h0);
   assign w_sel_tx     = (mem_addr == c_TXDATA_ADDR);
   assign w_sel_st     = (mem_addr == c_STATUS_ADDR);
   assign w_wr         = mem_w_enable & ~reset;
   assign w_fifo_full  = (r_count == c_COUNT_FULL);
   assign w_fifo_empty = (r_count == '0);
   assign w_push       = w_wr & w_sel_tx & ~w_fifo_full;
   assign w_pop        = (r_state == ST_IDLE) & ~w_fifo_empty;
   assign w_tx_busy    = (r_state != ST_IDLE);
   assign w_status     = {28'b0, r_overflow, w_tx_busy, w_fifo_empty, w_fifo_full};

   // RAM contents survive reset, so this array has no reset branch
   always_ff @(posedge clk) begin
      if (w_wr && w_sel_ram) begin
         r_ram[w_ram_idx] <= mem_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_rdata <= '0;
      end else if (mem_r_enable) begin
         if (w_sel_ram) begin
            mem_rdata <= r_ram[w_ram_idx];
         end else if (w_sel_st) begin
            mem_rdata <= w_status;
         end else begin
            mem_rdata <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo[r_wptr] <= mem_wdata[7:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wptr <= ptr_next(r_wptr);
         end
         if (w_pop) begin
            r_rptr <= ptr_next(r_rptr);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CW'(1);
            2'b01:   r_count <= r_count - c_CW'(1);
            default: r_count <= r_count;
         endcase
         if (w_wr && w_sel_st) begin
            r_overflow <= 1'b0;
         end else if (w_wr && w_sel_tx && w_fifo_full) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // uart_tx is loaded with the level of the state being entered
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         uart_tx <= 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               uart_tx <= 1'b1;
               if (w_pop) begin
                  r_shift <= r_fifo[r_rptr];
                  r_baud  <= '0;
                  r_state <= ST_START;
                  uart_tx <= 1'b0;
               end
            end
            ST_START: begin
               if (r_baud == c_BAUD_LAST) begin
                  r_baud  <= '0;
                  r_bit   <= '0;
                  r_state <= ST_DATA;
                  uart_tx <= r_shift[0];
               end else begin
                  r_baud <= r_baud + c_BW'(1);
               end
            end
            ST_DATA: begin
               if (r_baud == c_BAUD_LAST) begin
                  r_baud <= '0;
                  if (r_bit == 3'd7) begin
                     r_state <= ST_STOP;
                     uart_tx <= 1'b1;
                  end else begin
                     r_bit   <= r_bit + 3'd1;
                     r_shift <= {1'b0, r_shift[7:1]};
                     uart_tx <= r_shift[1];
                  end
               end else begin
                  r_baud <= r_baud + c_BW'(1);
               end
            end
            ST_STOP: begin
               uart_tx <= 1'b1;
               if (r_baud == c_BAUD_LAST) begin
                  r_baud  <= '0;
                  r_state <= ST_IDLE;
               end else begin
                  r_baud <= r_baud + c_BW'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               uart_tx <= 1'b1;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
